// File: rtl/pkt_slot_manager_pkg.sv
// pkt_slot_manager_pkg
// Shared defaults and state encoding for the packet-buffer slot manager.
// No ports; imported by pkt_slot_manager and its testbench.
package pkt_slot_manager_pkg;

  localparam int          SLOT_NUM_DEF  = 16;
  localparam int          SLOT_W_DEF    = 4;
  localparam int          AGE_W_DEF     = 16;
  localparam int unsigned AGE_LIMIT_DEF = 50000;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/pkt_slot_manager_if.sv
// pkt_slot_manager_if
// Handshake bundle between the slot manager and its clients.
//   alloc_req/alloc_grant/alloc_slot        : store-engine allocation
//   free_valid_t/free_slot_t/free_ready_t   : transmit recycle release
//   free_valid_a/free_slot_a/free_ready_a   : aging/discard release
//   age_tick/age_exp_valid/age_exp_slot/age_exp_ack : aging time base and expiry reports
// master = client side, slave = slot manager.
interface pkt_slot_manager_if #(
  parameter int SLOT_W = 4
);
  logic              alloc_req;
  logic              alloc_grant;
  logic [SLOT_W-1:0] alloc_slot;

  logic              free_valid_t;
  logic [SLOT_W-1:0] free_slot_t;
  logic              free_ready_t;

  logic              free_valid_a;
  logic [SLOT_W-1:0] free_slot_a;
  logic              free_ready_a;

  logic              age_tick;
  logic              age_exp_valid;
  logic [SLOT_W-1:0] age_exp_slot;
  logic              age_exp_ack;

  modport master (
    output alloc_req, free_valid_t, free_slot_t, free_valid_a, free_slot_a,
           age_tick, age_exp_ack,
    input  alloc_grant, alloc_slot, free_ready_t, free_ready_a,
           age_exp_valid, age_exp_slot
  );

  modport slave (
    input  alloc_req, free_valid_t, free_slot_t, free_valid_a, free_slot_a,
           age_tick, age_exp_ack,
    output alloc_grant, alloc_slot, free_ready_t, free_ready_a,
           age_exp_valid, age_exp_slot
  );
endinterface

// File: rtl/pkt_slot_manager_rr_arb2.sv
// rr_arb2
// Two-requester round-robin arbiter with a combinational grant.
//   clk, reset : clock, async active-low reset
//   en         : grants forced low when 0
//   valid[1:0] : requests (bit 0 is favoured after reset)
//   grant[1:0] : one-hot grant; a grant is also the accept, so the
//                pointer moves to the other requester on every grant
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] valid,
  output logic [1:0] grant
);

  logic ptr;  // 0 favours requester 0, 1 favours requester 1

  always_comb begin
    grant = 2'b00;
    if (en) begin
      grant[0] = valid[0] & (~valid[1] | ~ptr);
      grant[1] = valid[1] & (~valid[0] |  ptr);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        ptr <= 1'b0;
    else if (grant[0]) ptr <= 1'b1;
    else if (grant[1]) ptr <= 1'b0;
  end

endmodule

// File: rtl/pkt_slot_manager.sv
// pkt_slot_manager
// Allocates and reclaims payload slots of the packet buffer RAM and ages
// allocated slots.
//   clk, reset      : clock, async active-low reset
//   bus (slave)     : alloc / two release ports / aging handshakes
//   init_done       : free map fully built, manager in RUN
//   free_count      : number of free slots (registered)
//   err_double_free : sticky, a release named an already-free slot
// After reset the free map is filled one bit per cycle (INIT), then the
// manager serves requests (RUN). Grants and expiry reports are registered;
// release readies are combinational from the arbiter.
module pkt_slot_manager
  import pkt_slot_manager_pkg::*;
#(
  parameter int          SLOT_NUM  = SLOT_NUM_DEF,
  parameter int          SLOT_W    = SLOT_W_DEF,
  parameter int          AGE_W     = AGE_W_DEF,
  parameter int unsigned AGE_LIMIT = AGE_LIMIT_DEF
)(
  input  logic                clk,
  input  logic                reset,
  pkt_slot_manager_if.slave   bus,
  output logic                init_done,
  output logic [SLOT_W:0]     free_count,
  output logic                err_double_free
);

  localparam logic [AGE_W-1:0]    AGE_LIM    = AGE_W'(AGE_LIMIT);
  localparam logic [AGE_W-1:0]    AGE_LIM_M1 = AGE_W'(AGE_LIMIT - 1);
  localparam logic [SLOT_W-1:0]   LAST_SLOT  = SLOT_W'(SLOT_NUM - 1);
  localparam logic [SLOT_NUM-1:0] SLOT_ONE   = SLOT_NUM'(1);
  localparam logic [SLOT_W:0]     CNT_ONE    = (SLOT_W+1)'(1);

  // Lowest set bit index; 0 when the vector is empty (callers qualify).
  function automatic logic [SLOT_W-1:0] lsb_idx(input logic [SLOT_NUM-1:0] v);
    lsb_idx = '0;
    for (int i = SLOT_NUM-1; i >= 0; i--)
      if (v[i]) lsb_idx = SLOT_W'(i);
  endfunction

  state_e                       state, state_nxt;
  logic [SLOT_W-1:0]            addr_ini;
  logic [SLOT_NUM-1:0]          free_map, free_map_nxt;
  logic [SLOT_NUM-1:0]          pending, pending_keep, pending_nxt;
  logic [SLOT_NUM-1:0][AGE_W-1:0] age_cnt;
  logic [SLOT_NUM-1:0]          exp_set;

  logic                         run;
  logic [1:0]                   rel_gnt;
  logic                         rel_vld, rel_new, rel_dup;
  logic [SLOT_W-1:0]            rel_slot, gnt_slot;
  logic                         do_grant;
  logic [SLOT_NUM-1:0]          init_oh, gnt_oh, rel_oh, ack_oh;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_INIT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_INIT: if (addr_ini == LAST_SLOT) state_nxt = ST_RUN;
      ST_RUN:  state_nxt = ST_RUN;
      default: state_nxt = ST_INIT;
    endcase
  end

  assign run       = (state == ST_RUN);
  assign init_done = run;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      addr_ini <= '0;
    else if (!run)   addr_ini <= addr_ini + SLOT_W'(1);
  end

  // ---------------- release arbitration ----------------
  rr_arb2 u_rel_arb (
    .clk   (clk),
    .reset (reset),
    .en    (run),
    .valid ({bus.free_valid_a, bus.free_valid_t}),
    .grant (rel_gnt)
  );

  assign bus.free_ready_t = rel_gnt[0];
  assign bus.free_ready_a = rel_gnt[1];

  // ---------------- datapath decode ----------------
  always_comb begin
    rel_vld  = |rel_gnt;
    rel_slot = rel_gnt[1] ? bus.free_slot_a : bus.free_slot_t;
    rel_dup  = rel_vld &  free_map[rel_slot];
    rel_new  = rel_vld & ~free_map[rel_slot];

    // Allocation sees the registered (pre-release) map, so a slot released
    // this cycle is only grantable from the next one.
    do_grant = run & bus.alloc_req & (|free_map);
    gnt_slot = lsb_idx(free_map);

    init_oh = run      ? '0 : (SLOT_ONE << addr_ini);
    gnt_oh  = do_grant ? (SLOT_ONE << gnt_slot) : '0;
    rel_oh  = rel_vld  ? (SLOT_ONE << rel_slot) : '0;
    ack_oh  = (bus.age_exp_ack & bus.age_exp_valid) ? (SLOT_ONE << bus.age_exp_slot) : '0;

    free_map_nxt = (free_map & ~gnt_oh) | init_oh | (rel_new ? rel_oh : '0);

    // A release clears the pending bit and beats a same-cycle expiry
    // (exp_set is masked per slot); an ack clears only the reported bit.
    pending_keep = pending & ~(rel_oh | ack_oh);
    pending_nxt  = pending_keep | exp_set;
  end

  // ---------------- per-slot age counters ----------------
  for (genvar i = 0; i < SLOT_NUM; i++) begin : g_age
    logic aging;
    assign aging      = run & bus.age_tick & ~free_map[i];
    // Pending is raised only on the tick that reaches the limit, so a
    // saturated counter does not re-report after an ack.
    assign exp_set[i] = aging & (age_cnt[i] == AGE_LIM_M1) & ~rel_oh[i] & ~gnt_oh[i];

    always_ff @(posedge clk or negedge reset) begin
      if (!reset)                          age_cnt[i] <= '0;
      else if (gnt_oh[i] | rel_oh[i])      age_cnt[i] <= '0;
      else if (aging && age_cnt[i] != AGE_LIM) age_cnt[i] <= age_cnt[i] + AGE_W'(1);
    end
  end

  // ---------------- state registers ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      free_map          <= '0;
      pending           <= '0;
      free_count        <= '0;
      err_double_free   <= 1'b0;
      bus.alloc_grant   <= 1'b0;
      bus.alloc_slot    <= '0;
      bus.age_exp_valid <= 1'b0;
      bus.age_exp_slot  <= '0;
    end else begin
      free_map        <= free_map_nxt;
      pending         <= pending_nxt;
      err_double_free <= err_double_free | rel_dup;

      if (!run)                      free_count <= free_count + CNT_ONE;
      else if (rel_new && !do_grant) free_count <= free_count + CNT_ONE;
      else if (!rel_new && do_grant) free_count <= free_count - CNT_ONE;

      bus.alloc_grant <= do_grant;
      if (do_grant) bus.alloc_slot <= gnt_slot;

      // Report from the post-clear view so an acked or released slot is
      // never shown a second time; new expiries appear one cycle after
      // their pending bit.
      bus.age_exp_valid <= |pending_keep;
      bus.age_exp_slot  <= lsb_idx(pending_keep);
    end
  end

endmodule

// File: tb/tb_pkt_slot_manager.sv
module tb_pkt_slot_manager;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       init_done;
  logic [4:0] free_count;
  logic       err_double_free;

  int nchk  = 0;
  int nfail = 0;

  pkt_slot_manager_if #(.SLOT_W(4)) sif ();

  pkt_slot_manager #(
    .SLOT_NUM(16), .SLOT_W(4), .AGE_W(16), .AGE_LIMIT(4)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .bus             (sif),
    .init_done       (init_done),
    .free_count      (free_count),
    .err_double_free (err_double_free)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       req;
    logic       vt;
    logic [3:0] st;
    logic       va;
    logic [3:0] sa;
    logic       tick;
    logic       ack;
    logic       e_rt;
    logic       e_ra;
    logic       e_gnt;
    logic [3:0] e_slot;
    logic [4:0] e_cnt;
    logic       e_ev;
    logic [3:0] e_es;
    logic       e_err;
  } vec_t;

  localparam int NV = 46;
  vec_t vt[NV];

  function automatic vec_t mk(
    input logic req, input logic v_t, input int s_t, input logic v_a, input int s_a,
    input logic tick, input logic ack, input logic e_rt, input logic e_ra,
    input logic e_gnt, input int e_slot, input int e_cnt,
    input logic e_ev, input int e_es, input logic e_err);
    vec_t r;
    r.req = req; r.vt = v_t; r.st = 4'(s_t); r.va = v_a; r.sa = 4'(s_a);
    r.tick = tick; r.ack = ack; r.e_rt = e_rt; r.e_ra = e_ra;
    r.e_gnt = e_gnt; r.e_slot = 4'(e_slot); r.e_cnt = 5'(e_cnt);
    r.e_ev = e_ev; r.e_es = 4'(e_es); r.e_err = e_err;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    sif.alloc_req    = 1'b0;
    sif.free_valid_t = 1'b0;
    sif.free_slot_t  = '0;
    sif.free_valid_a = 1'b0;
    sif.free_slot_a  = '0;
    sif.age_tick     = 1'b0;
    sif.age_exp_ack  = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_init_done"},  32'(init_done),         0);
    chk({tag, "_grant"},      32'(sif.alloc_grant),   0);
    chk({tag, "_slot"},       32'(sif.alloc_slot),    0);
    chk({tag, "_free_count"}, 32'(free_count),        0);
    chk({tag, "_exp_valid"},  32'(sif.age_exp_valid), 0);
    chk({tag, "_exp_slot"},   32'(sif.age_exp_slot),  0);
    chk({tag, "_err"},        32'(err_double_free),   0);
  endtask

  // Releases reset at a negedge with a release and an alloc request held,
  // both of which must be ignored until init_done; counts edges to init_done.
  task automatic run_init(input string tag);
    int cycles = 0;
    @(negedge clk);
    reset = 1'b1;
    sif.alloc_req    = 1'b1;
    sif.free_valid_t = 1'b1;
    sif.free_slot_t  = 4'd0;
    while (!init_done && cycles < 40) begin
      @(posedge clk); #1;
      cycles++;
      if (!init_done) begin
        chk({tag, "_init_ready_t"}, 32'(sif.free_ready_t), 0);
        chk({tag, "_init_grant"},   32'(sif.alloc_grant),  0);
      end
    end
    idle_inputs();
    chk({tag, "_init_cycles"}, 32'(cycles), 16);
    chk({tag, "_init_count"},  32'(free_count), 16);
    chk({tag, "_init_err"},    32'(err_double_free), 0);
  endtask

  initial begin
    idle_inputs();

    // Vector table: each row is driven at a negedge; readies are checked
    // before the next posedge, registered outputs just after it.
    for (int i = 0; i < 16; i++)
      vt[i] = mk(1, 0,0, 0,0, 0,0, 0,0, 1,i, 15-i, 0,0, 0);
    vt[16] = mk(1, 0,0, 0,0, 0,0, 0,0, 0,0,  0, 0,0, 0);  // map empty: no grant
    vt[17] = mk(0, 1,5, 0,0, 0,0, 1,0, 0,0,  1, 0,0, 0);  // release 5
    vt[18] = mk(1, 0,0, 0,0, 0,0, 0,0, 1,5,  0, 0,0, 0);  // 5 re-granted
    vt[19] = mk(1, 1,6, 0,0, 0,0, 1,0, 0,0,  1, 0,0, 0);  // same-cycle: no grant
    vt[20] = mk(1, 0,0, 0,0, 0,0, 0,0, 1,6,  0, 0,0, 0);  // 6 granted next cycle
    vt[21] = mk(0, 0,0, 1,8, 0,0, 0,1, 0,0,  1, 0,0, 0);  // a alone, ptr -> t
    vt[22] = mk(0, 1,3, 1,7, 0,0, 1,0, 0,0,  2, 0,0, 0);  // both: t wins
    vt[23] = mk(0, 1,4, 1,7, 0,0, 0,1, 0,0,  3, 0,0, 0);  // both: a wins
    vt[24] = mk(0, 1,4, 0,0, 0,0, 1,0, 0,0,  4, 0,0, 0);
    vt[25] = mk(0, 0,0, 1,9, 0,0, 0,1, 0,0,  5, 0,0, 0);  // free 9
    vt[26] = mk(0, 1,9, 0,0, 0,0, 1,0, 0,0,  5, 0,0, 1);  // double free 9
    vt[27] = mk(0, 0,0, 0,0, 0,0, 0,0, 0,0,  5, 0,0, 1);  // sticky
    vt[28] = mk(0, 1,0, 0,0, 0,0, 1,0, 0,0,  6, 0,0, 1);
    vt[29] = mk(0, 0,0, 1,1, 0,0, 0,1, 0,0,  7, 0,0, 1);
    for (int i = 30; i < 33; i++)
      vt[i] = mk(0, 0,0, 0,0, 1,0, 0,0, 0,0, 7, 0,0, 1);
    vt[33] = mk(1, 1,5, 0,0, 1,0, 1,0, 1,0,  7, 0,0, 1);  // expiry tick; 5 released; grant 0
    vt[34] = mk(0, 0,0, 0,0, 0,0, 0,0, 0,0,  7, 1,2, 1);
    vt[35] = mk(0, 0,0, 0,0, 1,1, 0,0, 0,0,  7, 1,6, 1);
    vt[36] = mk(0, 0,0, 0,0, 1,1, 0,0, 0,0,  7, 1,10, 1);
    vt[37] = mk(0, 0,0, 0,0, 1,1, 0,0, 0,0,  7, 1,11, 1);
    vt[38] = mk(0, 0,0, 0,0, 1,1, 0,0, 0,0,  7, 1,12, 1); // ack + slot 0 expires
    vt[39] = mk(0, 0,0, 0,0, 0,0, 0,0, 0,0,  7, 1,0, 1);
    vt[40] = mk(0, 0,0, 0,0, 0,1, 0,0, 0,0,  7, 1,12, 1);
    vt[41] = mk(0, 0,0, 0,0, 0,1, 0,0, 0,0,  7, 1,13, 1);
    vt[42] = mk(0, 0,0, 0,0, 0,1, 0,0, 0,0,  7, 1,14, 1);
    vt[43] = mk(0, 0,0, 0,0, 0,1, 0,0, 0,0,  7, 1,15, 1);
    vt[44] = mk(0, 0,0, 0,0, 0,1, 0,0, 0,0,  7, 0,0, 1);
    vt[45] = mk(0, 0,0, 1,2, 0,0, 0,1, 0,0,  8, 0,0, 1);  // expired 2 freed on a

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("rst");
    run_init("first");

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      sif.alloc_req    = vt[i].req;
      sif.free_valid_t = vt[i].vt;
      sif.free_slot_t  = vt[i].st;
      sif.free_valid_a = vt[i].va;
      sif.free_slot_a  = vt[i].sa;
      sif.age_tick     = vt[i].tick;
      sif.age_exp_ack  = vt[i].ack;
      #1;
      chk($sformatf("v%0d_ready_t", i), 32'(sif.free_ready_t), 32'(vt[i].e_rt));
      chk($sformatf("v%0d_ready_a", i), 32'(sif.free_ready_a), 32'(vt[i].e_ra));
      @(posedge clk); #1;
      chk($sformatf("v%0d_grant", i), 32'(sif.alloc_grant), 32'(vt[i].e_gnt));
      if (vt[i].e_gnt)
        chk($sformatf("v%0d_slot", i), 32'(sif.alloc_slot), 32'(vt[i].e_slot));
      chk($sformatf("v%0d_count", i), 32'(free_count), 32'(vt[i].e_cnt));
      chk($sformatf("v%0d_exp_valid", i), 32'(sif.age_exp_valid), 32'(vt[i].e_ev));
      if (vt[i].e_ev)
        chk($sformatf("v%0d_exp_slot", i), 32'(sif.age_exp_slot), 32'(vt[i].e_es));
      chk($sformatf("v%0d_err", i), 32'(err_double_free), 32'(vt[i].e_err));
    end

    // Reset in the middle of a grant burst (free: 1,2,3,4,5,7,8,9)
    @(negedge clk);
    idle_inputs();
    sif.alloc_req = 1'b1;
    @(posedge clk); #1;
    chk("burst_g0", 32'(sif.alloc_grant), 1);
    chk("burst_s0", 32'(sif.alloc_slot), 1);
    @(posedge clk); #1;
    chk("burst_g1", 32'(sif.alloc_grant), 1);
    chk("burst_s1", 32'(sif.alloc_slot), 2);
    @(negedge clk);
    reset = 1'b0;
    sif.alloc_req = 1'b0;
    #1;
    chk_reset_vals("midrst");
    run_init("second");

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule

// File: doc/pkt_slot_manager.md
# pkt_slot_manager

Allocates and reclaims the 16 payload slots (128 words each) of the packet buffer RAM. It sits beside the packet buffer. It hands free slot IDs to the store engine, takes released slots back from two requesters (transmit recycle and aging/discard), and arbitrates between those two. It also runs per-slot age timers that flag slots held too long.

## Interface
- SLOT_NUM, 16, number of payload slots (power of two)
- SLOT_W, 4, slot ID width, log2(SLOT_NUM)
- AGE_W, 16, age counter width
- AGE_LIMIT, 16'd50000, age_tick count at which an allocated slot expires

- clk  in  1  clock
- reset  in  1  asynchronous, active-low
- init_done  out  1  high once the free map is fully built
- alloc_req  in  1  store engine requests one slot
- alloc_grant  out  1  one-cycle pulse; alloc_slot is valid while it is high
- alloc_slot  out  SLOT_W  granted slot ID
- free_valid_t / free_slot_t  in  1 / SLOT_W  transmit-side release
- free_ready_t  out  1  release accepted this cycle
- free_valid_a / free_slot_a  in  1 / SLOT_W  aging/discard release
- free_ready_a  out  1  release accepted this cycle
- age_tick  in  1  time-base pulse
- age_exp_valid  out  1  an expired slot is pending
- age_exp_slot  out  SLOT_W  lowest-index pending expired slot
- age_exp_ack  in  1  consumes the current expiry report
- free_count  out  SLOT_W+1  number of free slots
- err_double_free  out  1  sticky; set when a release names an already-free slot

## Operation
- State machine INIT -> RUN.
  - INIT: sets free_map bit addr_ini, with addr_ini running 0..SLOT_NUM-1, one bit per cycle.
  - After bit SLOT_NUM-1 is set, init_done goes 1 and the state moves to RUN.
  - alloc_req and releases are ignored in INIT (free_ready_* = 0).
- Allocation (RUN):
  - A grant happens when alloc_req=1 and free_map≠0.
  - The granted slot is the lowest-index set bit of free_map. That bit is cleared and the slot's age counter is zeroed.
  - At most one grant per cycle. If alloc_req=1 and free_map=0, no grant is made and the request must be held.
- Release arbitration:
  - Round-robin between the t and a ports. rr_ptr is 1 bit, reset to t.
  - free_ready_x is combinational: it is 1 if the port is valid and either the other port is not valid or rr_ptr favours this port.
  - On an accepted release, rr_ptr flips to the other port.
  - Exactly one release is accepted per cycle. The losing port holds valid and retries.
- Release effect:
  - Sets the free_map bit, clears the slot's age counter, and clears its expired-pending bit.
  - If the bit is already set, the map is unchanged and err_double_free is set. The release is still acknowledged.
- Aging:
  - On age_tick, each allocated slot's counter increments, saturating at AGE_LIMIT.
  - When a counter reaches AGE_LIMIT, that slot's pending bit is set.
  - age_exp_valid is the OR of all pending bits. age_exp_slot is the lowest pending index.
  - age_exp_ack clears the reported pending bit. The slot stays allocated until it is released through a free port.
- free_count = popcount(free_map), kept as a registered counter updated by +release −grant.

## Timing
- Reset values:
  - init_done=0, alloc_grant=0, alloc_slot=0, free_count=0, age_exp_valid=0, age_exp_slot=0, err_double_free=0.
  - free_map=0, all counters=0, pending=0, state INIT, addr_ini=0.
- init_done rises SLOT_NUM cycles after reset deasserts. free_count then reads SLOT_NUM.
- alloc_grant and alloc_slot are registered: the pulse appears the cycle after alloc_req is sampled.
- Release handshake:
  - valid&ready completes the transfer in the same cycle.
  - The freed bit is visible to allocation from the next cycle.
- Same-cycle grant and release:
  - Allocation uses the pre-release map.
  - free_count is unchanged net.
  - A slot released in cycle N cannot be granted before cycle N+1.
- Expiry: the pending bit is set the cycle after the age_tick that brings the counter to AGE_LIMIT. age_exp_valid follows one cycle later (registered).
- Same-cycle release and expiry of the same slot: the release wins and the pending bit stays clear.
- Same-cycle ack and new expiry: the ack clears the old bit and the new bit is set.
- Reset asserted mid-operation clears everything immediately and re-enters INIT.

## Structure
- Shared package holds SLOT_NUM, SLOT_W, AGE_W, AGE_LIMIT defaults, and the state encoding (INIT=0, RUN=1).
- Sub-module rr_arb2: 2-requester round-robin arbiter (valid[1:0] in, grant[1:0] out, pointer update on accept), reused by the transmit scheduler.
- Lowest-set-bit priority encoders are shared by allocation and expiry reporting as a function.

## Test plan
- Reset release -> init_done rises after 16 cycles, free_count=16. Then 16 back-to-back alloc_req -> slots 0..15 in order, free_count=0, and a 17th request gets no grant.
- All slots allocated; free_slot_t=5 accepted -> next alloc_req is granted slot 5 one cycle later; free_count goes 0->1->0.
- free_valid_t (slot 3) and free_valid_a (slot 7) held together -> t accepted first, a the next cycle, rr_ptr alternating; free_count +2.
- Slot 2 allocated, AGE_LIMIT=4, four age_ticks -> age_exp_valid with age_exp_slot=2; ack -> valid drops; slot still allocated until released on port a.
- Release of slot 9 while it is already free -> err_double_free=1 (sticky), free_count unchanged.
- Assert reset during a grant burst -> all outputs return to reset values; re-init completes in 16 cycles.
